// File: rtl/dual_issue_steer.sv
// Decode-side issue unit for the dual-issue pipeline.
// Holds one fetched pair, steers each instruction to the I-pipe (op != 0)
// or the R-pipe (op == 0), splits pairs that cannot issue together and
// interlocks on load-use hazards against the load in the I-pipe EX stage.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_EMPTY   | no valid slot, waiting for a fetch pair
// ST_PAIR    | slot0 and slot1 valid
// ST_SINGLE  | slot0 valid only (second half of a split pair)
module dual_issue_steer (
    input  logic        clk,
    input  logic        btnc_i,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] inst0,
    input  logic [31:0] inst1,
    input  logic [31:0] pc0,
    input  logic        flush,
    input  logic        ID_EX_MemRead_i,
    input  logic [31:0] ID_EX_rt_i,
    output logic [31:0] r1_ad_i,
    output logic [31:0] r2_ad_i,
    output logic [31:0] r1_ad_r,
    output logic [31:0] r2_ad_r,
    output logic        issue_valid_i,
    output logic        issue_valid_r,
    output logic [31:0] issue_inst_i,
    output logic [31:0] issue_inst_r,
    output logic [31:0] issue_pc_i,
    output logic [31:0] issue_pc_r
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_PAIR   = 2'd1;
    localparam logic [1:0] ST_SINGLE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d;
    logic [31:0] s0_inst_q, s0_inst_d, s1_inst_q, s1_inst_d;
    logic [31:0] s0_pc_q, s0_pc_d, s1_pc_q, s1_pc_d;

    logic        pair_ok, cand0, cand1, stall, go, v0, v1;
    logic [5:0]  dst0, dst1;

    function automatic logic is_ctrl(input logic [31:0] in);
        return (in[31:26] == 6'h02) || (in[31:26] == 6'h04) || (in[31:26] == 6'h05);
    endfunction

    function automatic logic is_alu_imm(input logic [31:0] in);
        return (in[31:29] == 3'b001);
    endfunction

    // {valid, reg}; a $0 destination is reported as no destination
    function automatic logic [5:0] dest_of(input logic [31:0] in);
        logic [4:0] r;
        r = 5'd0;
        if (in[31:26] == 6'h00)
            r = in[15:11];
        else if ((in[31:26] == 6'h23) || is_alu_imm(in))
            r = in[20:16];
        return {(r != 5'd0), r};
    endfunction

    function automatic logic uses_rt(input logic [31:0] in);
        return (in[31:26] == 6'h00) || (in[31:26] == 6'h2B) ||
               (in[31:26] == 6'h04) || (in[31:26] == 6'h05);
    endfunction

    function automatic logic uses_rs(input logic [31:0] in);
        return uses_rt(in) || (in[31:26] == 6'h23) || is_alu_imm(in);
    endfunction

    function automatic logic reads_reg(input logic [31:0] in, input logic [4:0] r);
        return (uses_rs(in) && (in[25:21] == r)) || (uses_rt(in) && (in[20:16] == r));
    endfunction

    // Pairing decision, load-use interlock and fetch handshake
    always_comb begin
        dst0    = dest_of(s0_inst_q);
        dst1    = dest_of(s1_inst_q);
        pair_ok = ((s0_inst_q[31:26] == 6'h00) != (s1_inst_q[31:26] == 6'h00)) &&
                  !is_ctrl(s0_inst_q) &&
                  !(dst0[5] && reads_reg(s1_inst_q, dst0[4:0])) &&
                  !(dst0[5] && dst1[5] && (dst0[4:0] == dst1[4:0]));
        cand0   = (state_q != ST_EMPTY) && s0_valid_q;
        cand1   = (state_q == ST_PAIR) && s1_valid_q && pair_ok;
        stall   = ID_EX_MemRead_i && (ID_EX_rt_i != 32'd0) && (ID_EX_rt_i[31:5] == 27'd0) &&
                  ((cand0 && reads_reg(s0_inst_q, ID_EX_rt_i[4:0])) ||
                   (cand1 && reads_reg(s1_inst_q, ID_EX_rt_i[4:0])));
        go      = !flush && !stall;
        v0      = cand0 && go;
        v1      = cand1 && go;
        fetch_ready = btnc_i && go &&
                      ((state_q == ST_EMPTY) || (state_q == ST_SINGLE) ||
                       ((state_q == ST_PAIR) && pair_ok));
    end

    // Route slot0 to its class pipe and a paired slot1 to the other pipe
    always_comb begin
        issue_valid_r = 1'b0;
        issue_inst_r  = 32'd0;
        issue_pc_r    = 32'd0;
        issue_valid_i = 1'b0;
        issue_inst_i  = 32'd0;
        issue_pc_i    = 32'd0;
        if (v0) begin
            if (s0_inst_q[31:26] == 6'h00) begin
                issue_valid_r = 1'b1;
                issue_inst_r  = s0_inst_q;
                issue_pc_r    = s0_pc_q;
            end else begin
                issue_valid_i = 1'b1;
                issue_inst_i  = s0_inst_q;
                issue_pc_i    = s0_pc_q;
            end
        end
        if (v1) begin
            if (s1_inst_q[31:26] == 6'h00) begin
                issue_valid_r = 1'b1;
                issue_inst_r  = s1_inst_q;
                issue_pc_r    = s1_pc_q;
            end else begin
                issue_valid_i = 1'b1;
                issue_inst_i  = s1_inst_q;
                issue_pc_i    = s1_pc_q;
            end
        end
        // idle pipes carry inst 0, so their addresses fall to 0 as well
        r1_ad_r = {27'd0, issue_inst_r[25:21]};
        r2_ad_r = {27'd0, issue_inst_r[20:16]};
        r1_ad_i = {27'd0, issue_inst_i[25:21]};
        r2_ad_i = {27'd0, issue_inst_i[20:16]};
    end

    // Slot/state update: flush, then stall hold, then consume and refill
    always_comb begin
        state_d    = state_q;
        s0_valid_d = s0_valid_q;
        s0_inst_d  = s0_inst_q;
        s0_pc_d    = s0_pc_q;
        s1_valid_d = s1_valid_q;
        s1_inst_d  = s1_inst_q;
        s1_pc_d    = s1_pc_q;
        if (flush) begin
            state_d    = ST_EMPTY;
            s0_valid_d = 1'b0;
            s1_valid_d = 1'b0;
        end else if (!stall) begin
            if (state_q == ST_PAIR && !pair_ok) begin
                state_d    = ST_SINGLE;
                s0_valid_d = s1_valid_q;
                s0_inst_d  = s1_inst_q;
                s0_pc_d    = s1_pc_q;
                s1_valid_d = 1'b0;
            end else if (state_q != ST_EMPTY) begin
                state_d    = ST_EMPTY;
                s0_valid_d = 1'b0;
                s1_valid_d = 1'b0;
            end
            if (fetch_valid && fetch_ready) begin
                state_d    = ST_PAIR;
                s0_valid_d = 1'b1;
                s0_inst_d  = inst0;
                s0_pc_d    = pc0;
                s1_valid_d = 1'b1;
                s1_inst_d  = inst1;
                s1_pc_d    = pc0 + 32'd4;
            end
        end
    end

    // Slot and state registers
    always_ff @(posedge clk or negedge btnc_i) begin
        if (!btnc_i) begin
            state_q    <= ST_EMPTY;
            s0_valid_q <= 1'b0;
            s0_inst_q  <= 32'd0;
            s0_pc_q    <= 32'd0;
            s1_valid_q <= 1'b0;
            s1_inst_q  <= 32'd0;
            s1_pc_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            s0_valid_q <= s0_valid_d;
            s0_inst_q  <= s0_inst_d;
            s0_pc_q    <= s0_pc_d;
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            s1_pc_q    <= s1_pc_d;
        end
    end

endmodule

// File: doc/dual_issue_steer.md
# dual_issue_steer

Decode-side issue unit of the dual-issue pipeline. It buffers the instruction pair delivered by fetch and steers each instruction to the I-pipe (non-zero opcode) or the R-pipe (opcode 0). It drives the four read addresses of the dual-port register file and the per-pipe instruction/valid/PC bundles captured by the ID/EX registers. When a pair cannot issue together, it splits the pair into two single issues, and it interlocks on load-use hazards against the I-pipe.

## Interface
- No parameters. Instruction and PC width fixed at 32; register addresses driven as 32-bit (5-bit field zero-extended).
- clk  in  1  rising-edge clock
- btnc_i  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetch presents a pair
- fetch_ready  out  1  pair accepted at this edge when fetch_valid=1
- inst0, inst1  in  32 each  older / younger instruction of the pair
- pc0  in  32  PC of inst0 (inst1 PC = pc0+4)
- flush  in  1  branch/jump redirect; discards buffered instructions
- ID_EX_MemRead_i  in  1  load currently in EX of I-pipe
- ID_EX_rt_i  in  32  destination of that load
- r1_ad_i, r2_ad_i, r1_ad_r, r2_ad_r  out  32 each  rs / rt read addresses per pipe, to register file
- issue_valid_i, issue_valid_r  out  1 each  pipe carries a real instruction this cycle
- issue_inst_i, issue_inst_r  out  32 each  instruction per pipe (0 = nop when invalid)
- issue_pc_i, issue_pc_r  out  32 each  PC per pipe (0 when invalid)

## Operation
- Storage: slot0, slot1, each holding {valid, inst, pc}. State is EMPTY (no valid slot), PAIR (both valid), or SINGLE (slot0 only).
- Decode per instruction (op = inst[31:26]):
  - class R if op==0, else I.
  - Control: op in {0x02 j, 0x04 beq, 0x05 bne}.
  - Destination: R → rd; lw (0x23) and ALU-immediate (0x08–0x0F) → rt; all others none. Destination $0 counts as none.
  - Sources: R, sw (0x2B), beq, bne → rs and rt; lw and ALU-immediate → rs; j → none.
- Pairing in PAIR: issue both iff all of the following hold:
  - the classes differ;
  - slot0 is not control;
  - slot1 reads no register that slot0 writes;
  - the two instructions do not write the same register.
- Otherwise issue slot0 alone to its class pipe, move slot1 into slot0, and go to SINGLE.
- SINGLE: issue slot0 alone, then go to EMPTY.
- Addresses: a pipe carrying an instruction drives r1_ad = inst[25:21] and r2_ad = inst[20:16]. An idle pipe drives 0.
- Load-use stall: ID_EX_MemRead_i=1, ID_EX_rt_i≠0, and ID_EX_rt_i equals a source of any instruction that would issue this cycle. Effect for that cycle:
  - both issue_valid are 0;
  - state and slots hold;
  - fetch_ready is 0.
- fetch_ready = !flush && !stall && (state==EMPTY || (state==SINGLE) || (state==PAIR && pair issues)). On fetch_valid && fetch_ready, the new pair is loaded into the slots and the state becomes PAIR.
- flush (highest priority):
  - both issue_valid forced 0 that cycle;
  - slots invalidated, state becomes EMPTY at the edge;
  - fetch ignored that cycle.
- Reset: state EMPTY, slots cleared. All outputs 0: fetch_ready=1 once reset deasserts, and the address/valid/inst/pc outputs are 0 during reset.

## Timing
- Slots and state are registered. All outputs are combinational from the slots, the state, and the stall/flush inputs.
- A pair accepted at edge N is visible on the addresses/issue bundles during cycle N+1 and is captured by ID/EX at edge N+1.
- Throughput:
  - pairable: 1 pair/cycle, back-to-back with no bubble;
  - split pair: 2 cycles, with the next fetch accepted at the end of the second issue cycle.
- Each stall cycle adds exactly one cycle. Stall and flush take effect in the cycle they are asserted.
- Simultaneous flush and stall: flush wins.
- Simultaneous flush and fetch_valid: fetch is not accepted.
- Reset asserted mid-split: the held instruction is lost and the outputs go to 0 immediately (asynchronous).

## Test plan
- Reset: assert btnc_i=0 in SINGLE state → all outputs 0 immediately. After release: fetch_ready=1, both valids 0.
- Independent pair: inst0=0x00221820 (add $3,$1,$2), inst1=0x20850001 (addi $5,$4,1), pc0=0x40 → next cycle:
  - both valids 1;
  - r1_ad_r=1, r2_ad_r=2, issue_pc_r=0x40;
  - r1_ad_i=4, issue_pc_i=0x44;
  - fetch_ready=1.
- RAW split: inst0=0x00221820, inst1=0x20650001 (addi $5,$3,1) → cycle 1: R-pipe only, fetch_ready=0. Cycle 2: I-pipe only, r1_ad_i=3, pc=0x44, fetch_ready=1.
- Same class / control: two addi → serialised over 2 cycles. beq followed by add → beq issues alone first.
- Load-use: ID_EX_MemRead_i=1, ID_EX_rt_i=1 with the independent pair above → one cycle with no valids and fetch_ready=0. MemRead drops → the pair issues unchanged. Also with ID_EX_rt_i=0 → no stall.
- Flush in SINGLE with fetch_valid=1 → no issue that cycle and the pair is not accepted. Next cycle: EMPTY, fetch_ready=1, held instruction never issues.
